// File: rtl/wb_master_pkg.sv
// Shared constants for the Wishbone B3 burst master: cycle/burst types, FSM codes,
// completion status codes and the per-beat CTI selection helper.
package wb_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_ACTIVE   = 2'b01;
    localparam logic [1:0] ST_RETRY    = 2'b10;
    localparam logic [1:0] ST_SPARE    = 2'b11;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'b00,
        STATUS_BUS_ERR   = 2'b01,
        STATUS_RETRY_EXH = 2'b10,
        STATUS_TIMEOUT   = 2'b11
    } status_e;

    // Single-beat commands use classic cycles; bursts flag the final beat as end-of-burst.
    function automatic logic [2:0] beat_cti(input logic single, input logic last);
        if (single)
            return CTI_CLASSIC;
        else if (last)
            return CTI_EOB;
        else
            return CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_master_watchdog.sv
// Response watchdog for the burst master; present only when WB_MASTER_TIMEOUT_EN is defined.
// Counts strobe cycles without an ack and flags expiry on the TIMEOUT-th one.
`ifdef WB_MASTER_TIMEOUT_EN
module wb_master_watchdog #(
    parameter int TIMEOUT = 255,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [CW-1:0] count;

    assign expired = count_en && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk) begin
        if (wb_rst || clear)
            count <= '0;
        else if (count_en && !expired)
            count <= count + CW'(1);
    end

endmodule
`endif

// File: rtl/wb_burst_master.sv
// Wishbone B3 master running single or linear incrementing bursts with bounded retry.
// Define WB_MASTER_TIMEOUT_EN to add the response watchdog (status 11 on expiry).
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 16,
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 255,
    localparam int LW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
    localparam int SW       = DW / 8
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [SW-1:0] wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic          start,
    input  logic [AW-1:0] address,
    input  logic [SW-1:0] selection,
    input  logic          write,
    input  logic [LW-1:0] burst_len,
    input  logic [DW-1:0] data_wr,
    input  logic          data_wr_valid,
    output logic          data_wr_ready,
    output logic [DW-1:0] data_rd,
    output logic          data_rd_valid,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status
);

    localparam int RCW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    logic [1:0]     state;
    logic [AW-1:0]  adr_q;
    logic [SW-1:0]  sel_q;
    logic           we_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  remaining;
    logic [RCW-1:0] retry_cnt;
    logic [DW-1:0]  data_rd_q;
    logic           rd_valid_q;
    logic           done_q;
    logic [1:0]     status_q;

    logic active, stb, beat_ack, beat_err, beat_rty, last_beat, timed_out;

    // Writes hold the strobe low until the engine supplies the next beat.
    assign active    = (state == ST_ACTIVE);
    assign stb       = active && (!we_q || data_wr_valid);
    assign beat_ack  = stb && wb_ack_i;
    assign beat_err  = stb && wb_err_i;
    assign beat_rty  = stb && wb_rty_i;
    assign last_beat = (remaining == '0);

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .clear    (!active || beat_ack),
        .count_en (stb),
        .expired  (timed_out)
    );
`else
    // No watchdog: the master waits on the slave indefinitely (false for any legal TIMEOUT).
    assign timed_out = (TIMEOUT < 0);
`endif

    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = data_wr;
    assign wb_sel_o      = sel_q;
    assign wb_we_o       = we_q;
    assign wb_cyc_o      = active;
    assign wb_stb_o      = stb;
    assign wb_cti_o      = active ? beat_cti(len_q == '0, last_beat) : CTI_CLASSIC;
    assign wb_bte_o      = BTE_LINEAR;
    assign data_wr_ready = beat_ack && we_q;
    assign data_rd       = data_rd_q;
    assign data_rd_valid = rd_valid_q;
    assign busy          = (state != ST_IDLE);
    assign done          = done_q;
    assign status        = status_q;

    // Response priority inside a beat: err, then rty, then ack, then watchdog expiry.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= ST_IDLE;
            adr_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            len_q      <= '0;
            remaining  <= '0;
            retry_cnt  <= '0;
            data_rd_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= STATUS_OK;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        adr_q     <= address;
                        sel_q     <= selection;
                        we_q      <= write;
                        len_q     <= burst_len;
                        remaining <= burst_len;
                        retry_cnt <= '0;
                        status_q  <= STATUS_OK;
                        state     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (beat_err) begin
                        status_q <= STATUS_BUS_ERR;
                        done_q   <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (beat_rty) begin
                        if (retry_cnt == RCW'(RETRY_MAX)) begin
                            status_q <= STATUS_RETRY_EXH;
                            done_q   <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + RCW'(1);
                            state     <= ST_RETRY;
                        end
                    end else if (beat_ack) begin
                        adr_q <= adr_q + AW'(SW);
                        if (!we_q) begin
                            data_rd_q  <= wb_dat_i;
                            rd_valid_q <= 1'b1;
                        end
                        if (last_beat) begin
                            status_q <= STATUS_OK;
                            done_q   <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            remaining <= remaining - LW'(1);
                        end
                    end else if (timed_out) begin
                        status_q <= STATUS_TIMEOUT;
                        done_q   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_RETRY: state <= ST_ACTIVE;
                ST_SPARE: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a behavioural slave and a beat scoreboard.
// The timeout scenario runs only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_burst_master;
    import wb_master_pkg::*;

    localparam logic [31:0] WBASE = 32'hA000_0000;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        start = 1'b0;
    logic [31:0] address = '0;
    logic [3:0]  selection = '0;
    logic        write = 1'b0;
    logic [3:0]  burst_len = '0;
    logic [31:0] data_wr = WBASE;
    logic        data_wr_valid = 1'b1;
    logic        data_wr_ready;
    logic [31:0] data_rd;
    logic        data_rd_valid, busy, done;
    logic [1:0]  status;

    int checks = 0;
    int failures = 0;

    int waits = 0;
    int rty_beat = -1;
    int err_beat = -1;
    bit rty_all = 1'b0;
    bit gap_mode = 1'b0;

    int   s_wcnt = 0;
    int   s_beat = 0;
    bit   s_rty_used = 1'b0;
    logic s_hit;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];

    wb_burst_master dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_cti_o      (wb_cti_o),
        .wb_bte_o      (wb_bte_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_rty_i      (wb_rty_i),
        .start         (start),
        .address       (address),
        .selection     (selection),
        .write         (write),
        .burst_len     (burst_len),
        .data_wr       (data_wr),
        .data_wr_valid (data_wr_valid),
        .data_wr_ready (data_wr_ready),
        .data_rd       (data_rd),
        .data_rd_valid (data_rd_valid),
        .busy          (busy),
        .done          (done),
        .status        (status)
    );

    always #5 wb_clk = ~wb_clk;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ ~a ^ 32'h1234_5678;
    endfunction

    assign wb_dat_i = rdata(wb_adr_o);

    // Slave: responds after 'waits' strobe cycles; err/rty injection keyed on acked-beat index.
    always_comb begin
        s_hit    = wb_cyc_o && wb_stb_o && (s_wcnt == waits);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (s_hit) begin
            if (s_beat == err_beat) begin
                wb_err_i = 1'b1;
                wb_ack_i = 1'b1;
            end else if (rty_all || (s_beat == rty_beat && !s_rty_used)) begin
                wb_rty_i = 1'b1;
            end else begin
                wb_ack_i = 1'b1;
            end
        end
    end

    always @(posedge wb_clk) begin
        if (wb_rst || (start && !busy)) begin
            s_beat     <= 0;
            s_rty_used <= 1'b0;
        end else begin
            if (wb_ack_i && !wb_err_i) s_beat <= s_beat + 1;
            if (wb_rty_i) s_rty_used <= 1'b1;
        end
        s_wcnt <= (wb_cyc_o && wb_stb_o && !s_hit) ? s_wcnt + 1 : 0;
    end

    // Write-data source: beat i carries WBASE+i; gap_mode toggles valid every cycle.
    initial begin
        int  wbeat;
        bit  took, accept;
        wbeat = 0;
        forever begin
            @(negedge wb_clk);
            took = data_wr_ready;
            @(posedge wb_clk);
            accept = start && !busy;
            #1;
            if (accept) wbeat = 0;
            else if (took) wbeat++;
            data_wr_valid = gap_mode ? !data_wr_valid : 1'b1;
            data_wr = WBASE + 32'(wbeat);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input int len, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.adr = addr + 32'(4 * i);
            b.cti = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
            b.we  = wr;
            b.sel = wr ? 4'h3 : 4'hF;
            b.dat = wr ? WBASE + 32'(i) : 32'h0;
            beat_q.push_back(b);
            if (!wr) rd_q.push_back(rdata(b.adr));
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] addr, input logic wr,
                               input logic [3:0] len, input bit inject,
                               output int cyc_starts, output int idle_busy, output int stb_cyc,
                               output int rd_pulses, output int wr_readies, output int gaps);
        int    n, extra;
        bit    cyc_prev, seen;
        beat_t e;
        cyc_starts = 0; idle_busy = 0; stb_cyc = 0; rd_pulses = 0; wr_readies = 0; gaps = 0;
        cyc_prev = 1'b0; seen = 1'b0; n = 0;
        @(posedge wb_clk); #1;
        address = addr; selection = wr ? 4'h3 : 4'hF; write = wr; burst_len = len; start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge wb_clk);
            if (wb_cyc_o && !cyc_prev) cyc_starts++;
            cyc_prev = wb_cyc_o;
            if (busy && !wb_cyc_o) idle_busy++;
            if (wb_stb_o) stb_cyc++;
            if (data_wr_ready) wr_readies++;
            if (wb_cyc_o && wb_we_o && !data_wr_valid) begin
                gaps++;
                check({tag, "_gap_stb"}, wb_stb_o, 0);
            end
            if (wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
                if (beat_q.size() == 0) begin
                    check({tag, "_extra_beat"}, 1, 0);
                end else begin
                    e = beat_q.pop_front();
                    check({tag, "_adr"}, wb_adr_o, e.adr);
                    check({tag, "_cti"}, wb_cti_o, e.cti);
                    check({tag, "_we"}, wb_we_o, e.we);
                    check({tag, "_sel"}, wb_sel_o, e.sel);
                    check({tag, "_bte"}, wb_bte_o, 0);
                    if (e.we) check({tag, "_wdat"}, wb_dat_o, e.dat);
                end
            end
            if (data_rd_valid) begin
                rd_pulses++;
                if (rd_q.size() == 0) check({tag, "_extra_rd"}, 1, 0);
                else check({tag, "_rdat"}, data_rd, rd_q.pop_front());
            end
            if (inject && n == 2) begin
                start = 1'b1; address = 32'h900; write = 1'b1; burst_len = 4'hF;
            end
            if (inject && n == 3) start = 1'b0;
            if (done) seen = 1'b1;
            n++;
        end
        check({tag, "_done"}, seen, 1);
        extra = 0;
        repeat (3) begin
            @(negedge wb_clk);
            if (done) extra++;
        end
        check({tag, "_done_once"}, extra, 0);
        check({tag, "_beats_left"}, beat_q.size(), 0);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        beat_q.delete();
        rd_q.delete();
    endtask

    initial begin
        int cs, ib, sc, rp, wrr, gp, extra;

        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_cti", wb_cti_o, 0);
        check("rst_bte", wb_bte_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_rd_valid", data_rd_valid, 0);
        check("rst_rd", data_rd, 0);
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;

        $display("[TB] single read @0x100, 2 wait states");
        waits = 2;
        applyStimulus(32'h100, 1'b0, 0, 1);
        checkOutput("t1", 32'h100, 1'b0, 4'd0, 1'b0, cs, ib, sc, rp, wrr, gp);
        check("t1_status", status, STATUS_OK);
        check("t1_cycles", cs, 1);
        check("t1_stb_cycles", sc, 3);
        check("t1_rd_pulses", rp, 1);

        $display("[TB] gapped write burst len 3 @0x200");
        waits = 0; gap_mode = 1'b1;
        applyStimulus(32'h200, 1'b1, 3, 4);
        checkOutput("t2", 32'h200, 1'b1, 4'd3, 1'b0, cs, ib, sc, rp, wrr, gp);
        gap_mode = 1'b0;
        check("t2_status", status, STATUS_OK);
        check("t2_wr_ready", wrr, 4);
        check("t2_gaps_seen", gp > 0, 1);
        check("t2_rd_pulses", rp, 0);

        $display("[TB] read burst len 7 @0x300, one retry on beat 3");
        waits = 1; rty_beat = 3;
        applyStimulus(32'h300, 1'b0, 7, 8);
        checkOutput("t3", 32'h300, 1'b0, 4'd7, 1'b0, cs, ib, sc, rp, wrr, gp);
        rty_beat = -1;
        check("t3_status", status, STATUS_OK);
        check("t3_cycles", cs, 2);
        check("t3_idle_gap", ib, 1);
        check("t3_rd_pulses", rp, 8);

        $display("[TB] retry on every attempt");
        waits = 0; rty_all = 1'b1;
        checkOutput("t4", 32'h400, 1'b0, 4'd0, 1'b0, cs, ib, sc, rp, wrr, gp);
        rty_all = 1'b0;
        check("t4_status", status, STATUS_RETRY_EXH);
        check("t4_cycles", cs, 4);
        check("t4_idle_gaps", ib, 3);
        check("t4_rd_pulses", rp, 0);

        $display("[TB] err+ack on beat 2 of read burst len 3");
        waits = 0; err_beat = 2;
        applyStimulus(32'h500, 1'b0, 3, 2);
        checkOutput("t5", 32'h500, 1'b0, 4'd3, 1'b0, cs, ib, sc, rp, wrr, gp);
        err_beat = -1;
        check("t5_status", status, STATUS_BUS_ERR);
        check("t5_rd_pulses", rp, 2);

        $display("[TB] start while busy is ignored");
        waits = 3;
        applyStimulus(32'h600, 1'b0, 1, 2);
        checkOutput("t6", 32'h600, 1'b0, 4'd1, 1'b1, cs, ib, sc, rp, wrr, gp);
        check("t6_status", status, STATUS_OK);
        check("t6_cycles", cs, 1);
        check("t6_busy_after", busy, 0);
        check("t6_cyc_after", wb_cyc_o, 0);

`ifdef WB_MASTER_TIMEOUT_EN
        $display("[TB] silent slave, watchdog abort");
        waits = 100000;
        checkOutput("t7", 32'h780, 1'b0, 4'd0, 1'b0, cs, ib, sc, rp, wrr, gp);
        waits = 0;
        check("t7_status", status, STATUS_TIMEOUT);
        check("t7_stb_cycles", sc, 255);
        check("t7_rd_pulses", rp, 0);
`endif

        $display("[TB] reset in the middle of a read burst");
        waits = 1;
        @(posedge wb_clk); #1;
        address = 32'h700; selection = 4'hF; write = 1'b0; burst_len = 4'd7; start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0;
        repeat (5) @(negedge wb_clk);
        check("t8_busy_before", busy, 1);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        check("t8_cyc", wb_cyc_o, 0);
        check("t8_stb", wb_stb_o, 0);
        check("t8_busy", busy, 0);
        check("t8_done", done, 0);
        check("t8_rd_valid", data_rd_valid, 0);
        check("t8_adr", wb_adr_o, 0);
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge wb_clk);
            if (done) extra++;
        end
        check("t8_no_done", extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
